gate_seq: RTL and testbench
===========================

# gate_seq

Sequential gate-program evaluator for the logic-optimization flow. Holds a small levelized netlist of 2-input gates in a program memory and evaluates it on one shared gate datapath, one gate per clock, into a net-value register file. Primary inputs are captured at start, constant nets 0/1 are hardwired, and results are read back through a registered read port. Used to check optimized netlists cycle-accurately against the original.

## Interface
- NUM_NETS, 16: net register count; power of two, ≥ PI_COUNT+3; NET_W = log2(NUM_NETS) (localparam)
- NUM_GATES, 8: program memory depth; CNT_W = ceil(log2(NUM_GATES+1)) (localparam)
- PI_COUNT, 4: primary inputs, mapped to nets 2..PI_COUNT+1
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- prog_we  in  1  program write strobe
- prog_addr  in  log2(NUM_GATES)  gate slot
- prog_data  in  2+3*NET_W  {op[1:0], y, a, b}
- gate_cnt  in  CNT_W  gates to execute, sampled with start
- pi  in  PI_COUNT  primary input values, sampled in LOAD
- start  in  1  run request
- busy  out  1  high in LOAD and EVAL
- done  out  1  one-cycle pulse in DONE
- err  out  1  sticky error flag
- rd_addr  in  NET_W  net to read
- rd_data  out  1  registered value of net[rd_addr]

## Operation
- Nets: net0 constant 0, net1 constant 1, nets 2..PI_COUNT+1 primary inputs, rest internal.
- Ops: 00 AND(a,b), 01 OR(a,b), 10 NOT(a) (b ignored), 11 BUF(a) (see Configuration).
- FSM IDLE→LOAD→EVAL→DONE→IDLE.
  - IDLE: start=1 latches gate_cnt into cnt_q, gate index g=0 → LOAD; otherwise stay.
  - LOAD: pi[k] → net[k+2]; internal nets cleared to 0; → EVAL if cnt_q≠0, else → DONE.
  - EVAL: reads net[a], net[b] combinationally from current registers, writes result to net[y] at the edge; g increments; after g=cnt_q-1 → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Program must be levelized: a gate sees results of all lower-indexed gates.
- Write to net y < PI_COUNT+2 (constant or PI): suppressed, err set.
- gate_cnt > NUM_GATES: clamped to NUM_GATES, err set.
- prog_we while busy: write ignored, err set. prog_we in IDLE/DONE: written at the edge.
- start while not IDLE: ignored, no error.
- start and prog_we same cycle in IDLE: both take effect; write is visible to EVAL.
- err cleared only by reset.
- Reset (any time, including mid-EVAL): state IDLE, busy=0, done=0, err=0, rd_data=0, all nets 0 except net1=1, program memory all zeros, cnt_q=0, g=0.

## Timing
- start sampled at edge T → LOAD cycle T+1, EVAL cycles T+2..T+1+N, done high cycle T+2+N, IDLE T+3+N. N=0: done at T+2.
- busy high T+1..T+1+N inclusive.
- Next start accepted earliest in the IDLE cycle T+3+N.
- rd_data: net[rd_addr] registered every cycle, 1-cycle latency; a same-edge net write returns the old value.
- Net result of gate g readable via rd_data from cycle T+4+g.

## Configuration
- GATE_SEQ_XOR_EN defined: op 11 = XOR(a,b).
- Not defined: op 11 = BUF(a), b ignored. No other difference; cycle timing identical.

## Test plan
- Reset mid-EVAL: assert rst_n=0 during gate 3 → busy=0, done=0, err=0, net1=1, other nets 0 on readback; later start with gate_cnt=0 gives done two cycles after start.
- 6-gate program (OR y6 a2 b3; AND y7 a6 b4; NOT y8 a7; OR y9 a2 b8; OR y10 a0 b8; OR y11 a1 b8), pi=4'b0111, start at T → done at T+8; nets 6..11 read 1,1,0,1,0,1.
- Same program, pi=4'b0000 → nets 6..11 read 0,0,1,1,1,1; err=0.
- Gate writing y=1, then gate_cnt=9 with NUM_GATES=8 → net1 stays 1, err=1, done at T+10 (8 gates).
- prog_we and repeated start during busy → memory unchanged, err=1, no second run, exactly one done pulse.
- op 11, a=2, b=3, pi=4'b0011 → net y = 0 with GATE_SEQ_XOR_EN, 1 without.

Source files
------------

// File: rtl/gate_seq.sv
// gate_seq: evaluates a levelized netlist of 2-input gates, one gate per clock, into a net register file.
// Optional GATE_SEQ_XOR_EN: op 11 becomes XOR(a,b); without it op 11 is BUF(a).
module gate_seq #(
   parameter  int NUM_NETS  = 16,
   parameter  int NUM_GATES = 8,
   parameter  int PI_COUNT  = 4,
   localparam int NET_W     = $clog2(NUM_NETS),
   localparam int CNT_W     = $clog2(NUM_GATES + 1),
   localparam int PA_W      = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1,
   localparam int PD_W      = 2 + 3 * NET_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                prog_we,
   input  logic [PA_W-1:0]     prog_addr,
   input  logic [PD_W-1:0]     prog_data,
   input  logic [CNT_W-1:0]    gate_cnt,
   input  logic [PI_COUNT-1:0] pi,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                err,
   input  logic [NET_W-1:0]    rd_addr,
   output logic                rd_data
);

   typedef struct packed {
      logic [1:0]       op;
      logic [NET_W-1:0] y;
      logic [NET_W-1:0] a;
      logic [NET_W-1:0] b;
   } gate_t;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_DONE} state_t;

   localparam logic [NET_W-1:0] FIRST_INT = NET_W'(PI_COUNT + 2);
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(NUM_GATES);
   localparam logic [PA_W:0]    SLOTS     = (PA_W + 1)'(NUM_GATES);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     g_q, g_d;
   logic [NUM_NETS-1:0]  nets_q, nets_d;
   gate_t                prog_q [NUM_GATES];
   gate_t                prog_d [NUM_GATES];
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 rd_q, rd_d;

   gate_t                gate;
   logic                 va, vb, res;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      g_d     = g_q;
      nets_d  = nets_q;
      prog_d  = prog_q;
      err_d   = err_q;
      rd_d    = nets_q[rd_addr];

      gate = prog_q[g_q[PA_W-1:0]];
      va   = nets_q[gate.a];
      vb   = nets_q[gate.b];
      case (gate.op)
         2'b00:   res = va & vb;
         2'b01:   res = va | vb;
         2'b10:   res = ~va;
         default: begin
`ifdef GATE_SEQ_XOR_EN
            res = va ^ vb;
`else
            res = va;
`endif
         end
      endcase

      // Program memory only changes outside LOAD/EVAL so a run sees a stable program.
      if (prog_we) begin
         if (state_q == S_LOAD || state_q == S_EVAL)
            err_d = 1'b1;
         else if ({1'b0, prog_addr} < SLOTS)
            prog_d[prog_addr] = gate_t'(prog_data);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               g_d     = '0;
               state_d = S_LOAD;
               if (gate_cnt > MAX_CNT) begin
                  cnt_d = MAX_CNT;
                  err_d = 1'b1;
               end else begin
                  cnt_d = gate_cnt;
               end
            end
         end
         S_LOAD: begin
            nets_d                 = '0;
            nets_d[1]              = 1'b1;
            nets_d[PI_COUNT+1:2]   = pi;
            state_d = (cnt_q != '0) ? S_EVAL : S_DONE;
         end
         S_EVAL: begin
            // Constants and primary inputs are read-only to the program.
            if (gate.y < FIRST_INT)
               err_d = 1'b1;
            else
               nets_d[gate.y] = res;
            g_d = g_q + CNT_W'(1);
            if (g_d == cnt_q)
               state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_LOAD) || (state_d == S_EVAL);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         g_q     <= '0;
         nets_q  <= NUM_NETS'(2);
         for (int i = 0; i < NUM_GATES; i++)
            prog_q[i] <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         g_q     <= g_d;
         nets_q  <= nets_d;
         prog_q  <= prog_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rd_q    <= rd_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign rd_data = rd_q;

endmodule

// File: tb/tb_gate_seq.sv
// Directed + randomized bench for gate_seq against a sequential gate-list reference model.
module tb_gate_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        prog_we = 1'b0;
   logic [2:0]  prog_addr = '0;
   logic [13:0] prog_data = '0;
   logic [3:0]  gate_cnt = '0;
   logic [3:0]  pi = '0;
   logic        start = 1'b0;
   logic        busy, done, err;
   logic [3:0]  rd_addr = '0;
   logic        rd_data;

   int vectors = 0;
   int miscompares = 0;

   // reference model: program as plain integer tables, nets as a bit array
   int m_op [8];
   int m_y  [8];
   int m_a  [8];
   int m_b  [8];
   bit m_net [16];
   bit m_err;

   gate_seq dut (
      .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .gate_cnt(gate_cnt), .pi(pi), .start(start),
      .busy(busy), .done(done), .err(err), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         m_op[i] = 0; m_y[i] = 0; m_a[i] = 0; m_b[i] = 0;
      end
      for (int n = 0; n < 16; n++) m_net[n] = 0;
      m_net[1] = 1;
      m_err = 0;
   endfunction

   function automatic void model_run(input int cnt, input logic [3:0] piv);
      int n;
      bit va, vb, v;
      n = (cnt > 8) ? 8 : cnt;
      if (cnt > 8) m_err = 1;
      for (int i = 0; i < 16; i++) m_net[i] = 0;
      m_net[1] = 1;
      for (int k = 0; k < 4; k++) m_net[k+2] = piv[k];
      for (int g = 0; g < n; g++) begin
         va = m_net[m_a[g]];
         vb = m_net[m_b[g]];
         case (m_op[g])
            0: v = va & vb;
            1: v = va | vb;
            2: v = !va;
`ifdef GATE_SEQ_XOR_EN
            default: v = va ^ vb;
`else
            default: v = va;
`endif
         endcase
         if (m_y[g] < 6) m_err = 1;
         else m_net[m_y[g]] = v;
      end
   endfunction

   task automatic write_gate(input int slot, input int op, input int y, input int a, input int b);
      logic [1:0] o; logic [3:0] yy, aa, bb;
      o = op[1:0]; yy = y[3:0]; aa = a[3:0]; bb = b[3:0];
      prog_addr = slot[2:0];
      prog_data = {o, yy, aa, bb};
      prog_we = 1'b1;
      tick;
      prog_we = 1'b0;
      m_op[slot] = op; m_y[slot] = y; m_a[slot] = a; m_b[slot] = b;
   endtask

   task automatic random_prog;
      for (int s = 0; s < 8; s++)
         write_gate(s, $urandom_range(3, 0), $urandom_range(15, 6),
                    $urandom_range(15, 0), $urandom_range(15, 0));
   endtask

   task automatic check_nets(input string tag);
      for (int n = 0; n < 16; n++) begin
         rd_addr = n[3:0];
         tick;
         chk($sformatf("%s_net%0d", tag, n), {31'b0, rd_data}, {31'b0, m_net[n]});
      end
   endtask

   task automatic run(input int cnt, input logic [3:0] piv, input string tag);
      int k, busy_n, exp_n;
      gate_cnt = cnt[3:0];
      pi = piv;
      start = 1'b1;
      tick;
      start = 1'b0;
      model_run(cnt, piv);
      exp_n = (cnt > 8) ? 8 : cnt;
      k = 0; busy_n = 0;
      while (done !== 1'b1 && k < 30) begin
         if (busy === 1'b1) busy_n++;
         tick;
         k++;
      end
      chk({tag, "_done_lat"}, k, exp_n + 1);
      chk({tag, "_busy_cycles"}, busy_n, exp_n + 1);
      tick;
      chk({tag, "_done_pulse"}, {31'b0, done}, 0);
      chk({tag, "_idle_busy"}, {31'b0, busy}, 0);
      chk({tag, "_err"}, {31'b0, err}, {31'b0, m_err});
      check_nets(tag);
   endtask

   task automatic do_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_busy"}, {31'b0, busy}, 0);
      chk({tag, "_done"}, {31'b0, done}, 0);
      chk({tag, "_err"}, {31'b0, err}, 0);
      chk({tag, "_rd"}, {31'b0, rd_data}, 0);
      tick;
      rst_n = 1'b1;
      model_reset();
      tick;
   endtask

   initial begin
      int dones;
      bit  xv;
      model_reset();
      do_reset("rst0");
      check_nets("rst0");

      // six-gate reference program
      write_gate(0, 1, 6, 2, 3);
      write_gate(1, 0, 7, 6, 4);
      write_gate(2, 2, 8, 7, 0);
      write_gate(3, 1, 9, 2, 8);
      write_gate(4, 1, 10, 0, 8);
      write_gate(5, 1, 11, 1, 8);
      run(6, 4'b0111, "p6a");
      for (int n = 6; n < 12; n++) begin
         rd_addr = n[3:0]; tick;
         chk($sformatf("p6a_fixed%0d", n), {31'b0, rd_data}, (32'h2B >> (n - 6)) & 1);
      end
      run(6, 4'b0000, "p6b");
      for (int n = 6; n < 12; n++) begin
         rd_addr = n[3:0]; tick;
         chk($sformatf("p6b_fixed%0d", n), {31'b0, rd_data}, (32'h3C >> (n - 6)) & 1);
      end

      // op 11 with both operands high
      write_gate(6, 3, 12, 2, 3);
      run(7, 4'b0011, "op11");
`ifdef GATE_SEQ_XOR_EN
      xv = 1'b0;
`else
      xv = 1'b1;
`endif
      rd_addr = 4'd12; tick;
      chk("op11_fixed", {31'b0, rd_data}, {31'b0, xv});

      for (int it = 0; it < 4; it++) begin
         random_prog();
         run($urandom_range(8, 0), 4'($urandom_range(15, 0)), $sformatf("rnd%0d", it));
      end

      // program write and repeated start while busy
      random_prog();
      gate_cnt = 4'd8; pi = 4'($urandom_range(15, 0)); start = 1'b1;
      dones = 0;
      tick;
      for (int c = 0; c < 4; c++) begin
         if (done === 1'b1) dones++;
         prog_addr = 3'd2; prog_data = 14'h3FFF; prog_we = 1'b1;
         tick;
      end
      prog_we = 1'b0; start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (done === 1'b1) dones++;
         tick;
      end
      m_err = 1;
      chk("busy_dones", dones, 1);
      chk("busy_err", {31'b0, err}, 1);
      run(8, pi, "busy_rerun");

      // asynchronous reset in the middle of gate 3
      gate_cnt = 4'd8; start = 1'b1;
      tick; start = 1'b0;
      tick; tick; tick; tick;
      do_reset("rst_mid");
      check_nets("rst_mid");
      run(0, 4'b1010, "zero_cnt");

      // gate_cnt above program depth
      random_prog();
      run(9, 4'($urandom_range(15, 0)), "clamp");

      // write to a constant net
      do_reset("rst_y1");
      random_prog();
      write_gate(0, 1, 1, 0, 0);
      run(8, 4'($urandom_range(15, 0)), "y1");
      rd_addr = 4'd1; tick;
      chk("y1_net1_fixed", {31'b0, rd_data}, 1);
      chk("y1_err_fixed", {31'b0, err}, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
